update_writer: RTL and testbench

//  Downstream of the SSSP slave stage. Captures its update stream (dout/dout_valid/dout_done),

---
 rtl/update_writer.sv | 128 ++++++++++++
 tb/tb_update_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/update_writer.sv
// Update-stream capture: buffers SSSP update lines and writes them
// to the host update buffer, then pulses done once every write is acknowledged.
module update_writer #(
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 42,
  parameter int AF_MARGIN  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [511:0]      dout,
  input  logic              dout_valid,
  input  logic              dout_done,
  output logic              wr_req_valid,
  input  logic              wr_req_ready,
  output logic [ADDR_W-1:0] wr_req_addr,
  output logic [511:0]      wr_req_data,
  input  logic              wr_rsp_valid,
  output logic              almost_full,
  output logic              overflow,
  output logic [31:0]       lines_written,
  output logic              done
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [511:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       req_count, rsp_count;
  logic              overflow_q;

  logic active, empty, full;
  logic push, pop, take;
  logic rsp_take, go;

  assign active = (state == STREAM) || (state == DRAIN);
  assign empty  = (count == '0);
  assign full   = (count == (PW+1)'(FIFO_DEPTH));
  assign pop    = active && !empty && wr_req_ready;
  assign push   = (state == STREAM) && dout_valid;
  // A full FIFO still takes a line when the head leaves in the same cycle
  assign take   = push && (!full || pop);
  assign rsp_take = active && wr_rsp_valid && (rsp_count < req_count);

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = STREAM;
          go       = 1'b1;
        end
      end
      STREAM: begin
        if (dout_done) state_nx = DRAIN;
      end
      DRAIN: begin
        if (empty && (rsp_count == req_count)) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      base_q     <= '0;
      req_count  <= '0;
      rsp_count  <= '0;
      overflow_q <= 1'b0;
    end else if (go) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      base_q     <= base_addr;
      req_count  <= '0;
      rsp_count  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (take) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        req_count <= req_count + 32'd1;
      end
      unique case ({take, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (rsp_take) rsp_count <= rsp_count + 32'd1;
      if (push && !take) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (take) mem[wr_ptr] <= dout;
  end

  assign wr_req_valid  = active && !empty;
  assign wr_req_data   = wr_req_valid ? mem[rd_ptr] : '0;
  assign wr_req_addr   = base_q + ADDR_W'(req_count);
  assign almost_full   = count >= (PW+1)'(FIFO_DEPTH - AF_MARGIN);
  assign overflow      = overflow_q;
  assign lines_written = rsp_count;
  assign done          = (state == DONE);

endmodule

// File: tb/tb_update_writer.sv
// Bench for update_writer: directed run sequence with random data,
// ready and responses, checked each cycle against a queue-based model.
module tb_update_writer;

  localparam int D  = 64;
  localparam int AW = 42;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] base_addr;
  logic [511:0]  dout;
  logic          dout_valid, dout_done;
  logic          wr_req_valid, wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [511:0]  wr_req_data;
  logic          wr_rsp_valid, almost_full, overflow;
  logic [31:0]   lines_written;
  logic          done;

  always #5 clk = ~clk;

  update_writer #(.FIFO_DEPTH(D), .ADDR_W(AW), .AF_MARGIN(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .dout(dout), .dout_valid(dout_valid), .dout_done(dout_done),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_rsp_valid(wr_rsp_valid), .almost_full(almost_full),
    .overflow(overflow), .lines_written(lines_written), .done(done)
  );

  // model: 0 idle, 1 streaming, 2 draining, 3 done pulse
  int            phase;
  logic [511:0]  q[$];
  logic [AW-1:0] m_base;
  int unsigned   req_n, rsp_n;
  bit            m_ov;
  int            pend;
  int            vectors, miscompares, done_obs;
  int            n, pushed;
  bit            dv;

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[AW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    phase  = 0;
    q.delete();
    m_base = '0;
    req_n  = 0;
    rsp_n  = 0;
    m_ov   = 0;
    pend   = 0;
  endtask

  task automatic check_outs();
    bit            ev;
    logic [AW-1:0] ea;
    ev = (phase == 1 || phase == 2) && q.size() > 0;
    ea = m_base + AW'(req_n);
    chk("valid", 512'(wr_req_valid), 512'(ev));
    if (ev) begin
      chk("data", wr_req_data, q[0]);
      chk("addr", 512'(wr_req_addr), 512'(ea));
    end
    chk("almost_full", 512'(almost_full), 512'(q.size() >= D - 8));
    chk("overflow", 512'(overflow), 512'(m_ov));
    chk("lines_written", 512'(lines_written), 512'(rsp_n));
    chk("done", 512'(done), 512'(phase == 3));
  endtask

  // rm: 0 no response, 1 random response while writes outstanding, 2 forced
  task automatic cyc(input bit rst, input bit st, input logic [AW-1:0] b,
                     input bit v, input bit dd, input bit rdy, input int rm);
    bit           rsp, pop, full, psh, ex;
    logic [511:0] d;
    d   = rnd512();
    rsp = (rm == 2) || (rm == 1 && pend > 0 && $urandom_range(0, 2) == 0);
    reset        = rst;
    start        = st;
    base_addr    = b;
    dout         = d;
    dout_valid   = v;
    dout_done    = dd;
    wr_req_ready = rdy;
    wr_rsp_valid = rsp;
    #1;
    check_outs();
    if (done) done_obs++;
    @(posedge clk);
    if (rsp && pend > 0) pend--;
    if (rst) mreset();
    else begin
      case (phase)
        0: if (st) begin
          phase = 1; m_base = b; q.delete();
          req_n = 0; rsp_n = 0; m_ov = 0;
        end
        1, 2: begin
          full = q.size() == D;
          pop  = q.size() > 0 && rdy;
          psh  = phase == 1 && v;
          ex   = phase == 2 && q.size() == 0 && rsp_n == req_n;
          if (rsp && rsp_n < req_n) rsp_n++;
          if (pop) begin
            void'(q.pop_front());
            req_n++;
            pend++;
          end
          if (psh) begin
            if (full && !pop) m_ov = 1;
            else q.push_back(d);
          end
          if (phase == 1 && dd) phase = 2;
          else if (ex) phase = 3;
        end
        default: phase = 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic drain(input bit rr, input string tag);
    int i;
    i = 0;
    while (phase != 0 && i < 400) begin
      cyc(0, 0, '0, 0, 0, rr ? ($urandom_range(0, 3) != 0) : 1'b1, 1);
      i++;
    end
    chk({tag, "_finished"}, 512'(phase == 0), 512'(1));
    chk({tag, "_done_pulses"}, 512'(done_obs), 512'(1));
  endtask

  initial begin
    vectors = 0; miscompares = 0; done_obs = 0;
    reset = 1; start = 0; base_addr = '0; dout = '0;
    dout_valid = 0; dout_done = 0; wr_req_ready = 0; wr_rsp_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mreset();
    chk("rst_valid", 512'(wr_req_valid), 512'(0));
    chk("rst_addr", 512'(wr_req_addr), 512'(0));
    chk("rst_data", wr_req_data, 512'(0));
    chk("rst_lw", 512'(lines_written), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_ov", 512'(overflow), 512'(0));
    chk("rst_af", 512'(almost_full), 512'(0));
    cyc(1, 0, '0, 1, 1, 1, 2);
    cyc(0, 0, '0, 1, 1, 1, 2);

    // four lines at 0x100
    done_obs = 0;
    cyc(0, 1, AW'('h100), 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1, i == 3, 1, 1);
    drain(0, "t1");
    chk("t1_lw", 512'(lines_written), 512'(4));

    // ten-line burst with a 20-cycle stall; mid-run start ignored
    done_obs = 0;
    cyc(0, 1, rnd_addr(), 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, i == 5, rnd_addr(), 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, '0, 0, 0, 0, 1);
    cyc(0, 0, '0, 0, 1, 1, 1);
    drain(1, "t2");
    chk("t2_lw", 512'(lines_written), 512'(10));
    chk("t2_ov", 512'(overflow), 512'(0));

    // 70 lines into a 64-deep FIFO with no drain
    done_obs = 0;
    cyc(0, 1, rnd_addr(), 0, 0, 0, 1);
    for (int i = 0; i < 70; i++) cyc(0, 0, '0, 1, i == 69, 0, 1);
    chk("t3_af", 512'(almost_full), 512'(1));
    chk("t3_ov", 512'(overflow), 512'(1));
    drain(0, "t3");
    chk("t3_lw", 512'(lines_written), 512'(64));
    chk("t3_ov_held", 512'(overflow), 512'(1));

    // push and pop together while full
    done_obs = 0;
    cyc(0, 1, rnd_addr(), 0, 0, 0, 1);
    for (int i = 0; i < 64; i++) cyc(0, 0, '0, 1, 0, 0, 1);
    cyc(0, 0, '0, 1, 0, 1, 1);
    cyc(0, 0, '0, 1, 1, 1, 1);
    chk("t3b_ov", 512'(overflow), 512'(0));
    drain(1, "t3b");
    chk("t3b_lw", 512'(lines_written), 512'(66));

    // empty run
    done_obs = 0;
    cyc(0, 1, rnd_addr(), 0, 0, 1, 1);
    cyc(0, 0, '0, 0, 1, 1, 1);
    drain(0, "t4");
    chk("t4_lw", 512'(lines_written), 512'(0));

    // address wrap
    done_obs = 0;
    cyc(0, 1, 42'h3FF_FFFF_FFFE, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1, i == 3, 1, 1);
    drain(0, "t5");
    chk("t5_lw", 512'(lines_written), 512'(4));

    // reset in DRAIN with writes outstanding
    cyc(0, 1, rnd_addr(), 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, '0, 1, i == 4, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 0, 1, 0);
    cyc(1, 0, '0, 0, 0, 1, 0);
    chk("t6_valid", 512'(wr_req_valid), 512'(0));
    chk("t6_addr", 512'(wr_req_addr), 512'(0));
    chk("t6_lw", 512'(lines_written), 512'(0));
    chk("t6_done", 512'(done), 512'(0));
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 0, 1, 2);
    chk("t6_lw_after", 512'(lines_written), 512'(0));
    done_obs = 0;
    cyc(0, 1, rnd_addr(), 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, '0, 1, i == 5, 1, 1);
    drain(1, "t6");
    chk("t6_lw_rerun", 512'(lines_written), 512'(6));

    // random runs
    for (int r = 0; r < 4; r++) begin
      done_obs = 0;
      n = $urandom_range(1, 40);
      pushed = 0;
      cyc(0, 1, rnd_addr(), 0, 0, 1, 1);
      while (pushed < n) begin
        dv = $urandom_range(0, 1) == 1;
        cyc(0, 0, '0, dv, dv && pushed == n - 1,
            $urandom_range(0, 3) != 0, 1);
        if (dv) pushed++;
      end
      drain(1, "rnd");
      chk("rnd_lw", 512'(lines_written), 512'(n));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
